// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
//   Round-robin transmit scheduler: up to 8 byte requesters share one serial
//   TX line. Grants one requester at a time and sends its byte as an 8N1
//   frame (start bit, 8 data bits LSB first, stop bit). Each bit lasts one
//   period of the baud generator tick.
//
// Ports
//   clk        system clock
//   rstb       asynchronous active-low reset
//   tx_clk_en  one-cycle bit-period tick from the baud generator
//   req        per-requester byte-valid
//   data       flattened bytes, requester i on bits [8i+7:8i]
//   ack        one-cycle pulse: the byte of that requester has been captured
//   gnt_id     index of the requester currently or last granted
//   busy       a frame is pending or in progress
//   txd        serial output, idle high
// -----------------------------------------------------------------------------
module uart_tx_sched #(
  parameter int NUM_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 tx_clk_en,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [2:0]           gnt_id,
  output logic                 busy,
  output logic                 txd
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state;
  logic [2:0]  last;
  logic [2:0]  bitcnt;
  logic [7:0]  shreg;

  // Requests and bytes widened to the 8-requester maximum so the 3-bit
  // arbitration index can address them directly for any legal NUM_REQ.
  logic [7:0]  req_ext;
  logic [63:0] data_ext;
  logic [2:0]  sel;
  logic [2:0]  cand;
  logic        found;
  logic [7:0]  byte_sel;

  assign req_ext  = 8'(req);
  assign data_ext = 64'(data);
  assign byte_sel = data_ext[{sel, 3'b000} +: 8];

  // Round-robin search: first requester after the last winner, wrapping
  // modulo NUM_REQ. The last winner itself is checked last.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    sel   = last;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = 3'((int'(last) + k) % NUM_REQ);
      if (!found && req_ext[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state  <= IDLE;
      txd    <= 1'b1;
      ack    <= '0;
      busy   <= 1'b0;
      gnt_id <= '0;
      last   <= 3'(NUM_REQ - 1);
      bitcnt <= '0;
      shreg  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge register values regardless of statement order.
      ack <= '0;  // ack is a single-cycle pulse unless set below
      case (state)
        IDLE: begin
          txd <= 1'b1;
          // Ticks are ignored here; only a request moves the block on.
          if (|req) begin
            shreg  <= byte_sel;
            gnt_id <= sel;
            ack    <= NUM_REQ'(8'd1 << sel);
            last   <= sel;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          // The tick on the arbitration edge was seen in IDLE, so the start
          // bit always waits for the next tick.
          if (tx_clk_en) begin
            txd   <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (tx_clk_en) begin
            txd    <= shreg[0];
            shreg  <= {1'b0, shreg[7:1]};
            bitcnt <= '0;
            state  <= DATA;
          end
        end
        DATA: begin
          if (tx_clk_en) begin
            if (bitcnt == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              txd    <= shreg[0];
              shreg  <= {1'b0, shreg[7:1]};
              bitcnt <= bitcnt + 3'd1;
            end
          end
        end
        STOP: begin
          if (tx_clk_en) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          txd   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sched
//   Self-checking bench for uart_tx_sched (NUM_REQ=4, tick every 16 clocks).
//   Requesters are modelled as byte queues: req[i] is high while queue i is
//   non-empty and data[i] shows its head byte, which is popped on ack.
//   The reference predicts the winner from the round-robin rule, the start
//   cycle as the first tick strictly after arbitration, and the line level
//   at the middle of every bit period.
// -----------------------------------------------------------------------------
module tb_uart_tx_sched;

  localparam int NUM_REQ = 4;
  localparam int TICK    = 16;

  logic                 clk = 1'b0;
  logic                 rstb;
  logic                 tick_en;
  logic                 tx_clk_en;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] data;
  logic [NUM_REQ-1:0]   ack;
  logic [2:0]           gnt_id;
  logic                 busy;
  logic                 txd;

  int cyc = 0;  // number of rising edges so far

  uart_tx_sched #(.NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .tx_clk_en (tx_clk_en),
    .req       (req),
    .data      (data),
    .ack       (ack),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .txd       (txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Tick lands on every rising edge whose number is a multiple of TICK.
  assign tx_clk_en = tick_en && (((cyc + 1) % TICK) == 0);

  // Reference state
  logic [7:0] q [NUM_REQ][$];
  int  m_last;
  int  prev_end;
  bit  pending;
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic refresh();
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i]          = (q[i].size() != 0);
      data[8*i +: 8]  = (q[i].size() != 0) ? q[i][0] : 8'h00;
    end
  endtask

  task automatic push(input int id, input logic [7:0] b);
    q[id].push_back(b);
    refresh();
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int lst);
    for (int k = 1; k <= NUM_REQ; k++)
      if (r[(lst + k) % NUM_REQ]) return (lst + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic wait_cyc(input int t);
    if (cyc > t) check("schedule", cyc, t);
    while (cyc < t) @(negedge clk);
  endtask

  // Check one frame whose start bit is the first tick strictly after 'from'.
  task automatic check_frame(input int from, input logic [7:0] b);
    int s;
    s = (from / TICK + 1) * TICK;
    if (cyc <= s - 1) begin
      wait_cyc(s - 1);
      check("pre_start_txd", txd, 1);
      check("load_busy", busy, 1);
    end
    wait_cyc(s);
    check("start_bit", txd, 0);
    for (int k = 0; k < 8; k++) begin
      wait_cyc(s + TICK * (k + 1) + TICK / 2);
      check($sformatf("data_bit%0d", k), txd, b[k]);
      check("ack_quiet", ack, 0);
    end
    wait_cyc(s + TICK * 9 + TICK / 2);
    check("stop_bit", txd, 1);
    wait_cyc(s + TICK * 10 - 1);
    check("busy_before_stop_tick", busy, 1);
    wait_cyc(s + TICK * 10);
    check("busy_after_stop_tick", busy, 0);
    check("idle_txd", txd, 1);
    prev_end = s + TICK * 10;
    pending  = (req != '0);
  endtask

  // Wait for an ack, check arbitration, then check the frame.
  //   exp_id      directed expected winner, -1 for model only
  //   hold        cycles with ticks stopped after ack (0: ticks running)
  //   late_id     requester given a byte right after ack; -1 none, -2 random
  //   abort_after return this many cycles after ack without checking the frame
  task automatic serve(input int exp_id, input int hold, input int late_id, input int abort_after);
    int e, pred, from, waited;
    logic [NUM_REQ-1:0] rsnap;
    logic [7:0] b;
    waited = 0;
    while (ack == '0 && waited < 600) begin
      @(negedge clk);
      waited++;
    end
    check("ack_seen", (ack != '0), 1);
    if (ack == '0) return;
    e     = cyc;
    rsnap = req;
    pred  = rr_pick(rsnap, m_last);
    if (pred < 0) begin
      check("ack_without_req", ack, 0);
      return;
    end
    if (pending) check("b2b_arb_cycle", e, prev_end + 1);
    check("ack_onehot", ack, 1 << pred);
    check("gnt_id", gnt_id, pred);
    if (exp_id >= 0) check("gnt_expected", gnt_id, exp_id);
    check("busy_rise", busy, 1);
    b = q[pred].pop_front();
    refresh();
    m_last  = pred;
    pending = 1'b0;
    if (late_id >= 0) push(late_id, 8'($urandom));
    else if (late_id == -2 && $urandom_range(1, 0) == 1)
      push(int'($urandom_range(NUM_REQ - 1, 0)), 8'($urandom));
    @(negedge clk);
    check("ack_pulse_len", ack, 0);
    if (abort_after > 0) begin
      repeat (abort_after) @(negedge clk);
      return;
    end
    from = e;
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        check("hold_txd", txd, 1);
        check("hold_busy", busy, 1);
      end
      tick_en = 1'b1;
      from    = cyc;
    end
    check_frame(from, b);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    rstb     = 1'b0;
    tick_en  = 1'b1;
    req      = '0;
    data     = '0;
    m_last   = NUM_REQ - 1;
    pending  = 1'b0;
    prev_end = 0;

    // Power-on reset values
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_gnt_id", gnt_id, 0);
    rstb = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy_no_req", busy, 0);

    // Single byte on requester 1
    push(1, 8'hA5);
    serve(1, 0, -1, 0);

    // Reset in the middle of a frame
    push(3, 8'h3C);
    serve(3, 0, -1, 60);
    check("midframe_busy", busy, 1);
    #2 rstb = 1'b0;
    #1;
    check("midrst_txd", txd, 1);
    check("midrst_ack", ack, 0);
    check("midrst_busy", busy, 0);
    check("midrst_gnt_id", gnt_id, 0);
    m_last  = NUM_REQ - 1;
    pending = 1'b0;

    // Simultaneous requests presented during reset
    push(0, 8'h11);
    push(1, 8'h22);
    push(2, 8'h33);
    push(3, 8'h44);
    @(negedge clk);
    rstb = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) serve(i, 0, -1, 0);

    // Fairness: 0 and 2 held high for three bytes each
    for (int i = 0; i < 3; i++) begin
      push(0, 8'($urandom));
      push(2, 8'($urandom));
    end
    for (int i = 0; i < 6; i++) serve((i % 2) * 2, 0, -1, 0);

    // Arbitration on a tick edge: start bit must wait for the next tick
    while (((cyc + 1) % TICK) != 0) @(negedge clk);
    push(1, 8'h96);
    serve(1, 0, -1, 0);

    // Ticks held low after ack: stay in LOAD with the line high
    tick_en = 1'b0;
    push(3, 8'h5A);
    serve(3, 40, -1, 0);

    // Late request raised during another requester's frame
    push(0, 8'hC3);
    serve(0, 0, 2, 0);
    serve(2, 0, -1, 0);

    // Randomized traffic with random late arrivals
    repeat (30) begin
      if (req == '0)
        repeat ($urandom_range(3, 1)) push(int'($urandom_range(NUM_REQ - 1, 0)), 8'($urandom));
      serve(-1, 0, -2, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
